calc_key_engine: RTL and testbench

- Receiving end of the keypad cursor interface: consumes the 5-bit key code selected on the 6x4 grid and turns key presses into a two-operand calculator.
- Accumulates operand digits (hex or decimal), latches the operator, executes on EXE and drives the display value.
- Produces the `restriction` signal that limits the cursor to decimal keys when in decimal mode.
- Sits between the grid cursor / press debouncer and the display driver.

---
 rtl/calc_key_engine_pkg.sv | 42 ++++
 rtl/calc_key_engine_if.sv | 21 ++
 rtl/calc_seq_mult.sv | 53 +++++
 rtl/calc_key_engine.sv | 184 ++++++++++++++++++
 tb/tb_calc_key_engine.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/calc_key_engine_pkg.sv
// Shared key codes, operator and state encodings for the keypad calculator.
package calc_pkg;

    localparam logic [4:0] K_ADD = 5'h10;
    localparam logic [4:0] K_MUL = 5'h11;
    localparam logic [4:0] K_AND = 5'h12;
    localparam logic [4:0] K_EXE = 5'h13;
    localparam logic [4:0] K_SUB = 5'h14;
    localparam logic [4:0] K_OR  = 5'h15;
    localparam logic [4:0] K_CE  = 5'h16;
    localparam logic [4:0] K_CLR = 5'h17;

    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_ADD  = 3'd1,
        OP_SUB  = 3'd2,
        OP_MUL  = 3'd3,
        OP_AND  = 3'd4,
        OP_OR   = 3'd5
    } op_t;

    typedef enum logic [2:0] {
        S_A   = 3'd0,
        S_OP  = 3'd1,
        S_B   = 3'd2,
        S_MUL = 3'd3,
        S_RES = 3'd4
    } state_t;

    // Non-operator codes map to OP_NONE so callers can use it as "is operator".
    function automatic op_t key_to_op(input logic [4:0] code);
        case (code)
            K_ADD:   return OP_ADD;
            K_SUB:   return OP_SUB;
            K_MUL:   return OP_MUL;
            K_AND:   return OP_AND;
            K_OR:    return OP_OR;
            default: return OP_NONE;
        endcase
    endfunction

endpackage

// File: rtl/calc_key_engine_if.sv
// Key input / display output bundle between the cursor side and the key engine.
interface calc_key_engine_if #(parameter int W = 16);
    logic         key_valid;
    logic [4:0]   key_code;
    logic         dec_mode;
    logic         restriction;
    logic [W-1:0] display_val;
    logic [2:0]   op_sel;
    logic         ovf;
    logic         busy;

    modport master (
        output key_valid, key_code, dec_mode,
        input  restriction, display_val, op_sel, ovf, busy
    );

    modport slave (
        input  key_valid, key_code, dec_mode,
        output restriction, display_val, op_sel, ovf, busy
    );
endinterface

// File: rtl/calc_seq_mult.sv
// W-cycle shift-add multiplier; product/done present the result of the step in flight.
module calc_seq_mult #(
    parameter int W = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           abort,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           done,
    output logic [2*W-1:0] product
);
    localparam int CW = $clog2(W + 1);

    logic [2*W-1:0] mcand_reg;
    logic [2*W-1:0] acc_reg;
    logic [W-1:0]   mplier_reg;
    logic [CW-1:0]  cnt_reg;
    logic           run_reg;
    logic [2*W-1:0] step;

    // Exposing acc+step lets the consumer take the product on the last step's edge.
    assign step    = mplier_reg[0] ? mcand_reg : '0;
    assign product = acc_reg + step;
    assign done    = run_reg && (cnt_reg == CW'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcand_reg  <= '0;
            acc_reg    <= '0;
            mplier_reg <= '0;
            cnt_reg    <= '0;
            run_reg    <= 1'b0;
        end else if (abort) begin
            run_reg <= 1'b0;
        end else if (start) begin
            mcand_reg  <= {{W{1'b0}}, a};
            mplier_reg <= b;
            acc_reg    <= '0;
            cnt_reg    <= CW'(W);
            run_reg    <= 1'b1;
        end else if (run_reg) begin
            acc_reg    <= product;
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
            cnt_reg    <= cnt_reg - CW'(1);
            if (cnt_reg == CW'(1)) begin
                run_reg <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/calc_key_engine.sv
// Two-operand keypad calculator: digit entry, operator latch, execute, display select.
module calc_key_engine
    import calc_pkg::*;
#(
    parameter int W          = 16,
    parameter int MAX_DIGITS = 4
) (
    input logic              clk,
    input logic              rst,
    calc_key_engine_if.slave bus
);
    localparam int CW = $clog2(MAX_DIGITS + 1);

    logic [W-1:0]   a_reg;
    logic [W-1:0]   b_reg;
    logic [CW-1:0]  cnt_reg;
    op_t            op_reg;
    state_t         state_reg;
    logic           ovf_reg;
    logic           busy_reg;
    logic           restriction_reg;

    logic           is_digit;
    logic           is_op;
    logic           is_exe;
    logic           is_ce;
    logic           is_clr;
    logic           room;
    logic [3:0]     digit;
    op_t            key_op;
    logic [W:0]     sum;
    logic [W-1:0]   diff;
    logic           start_mul;
    logic           abort_mul;
    logic           mul_done;
    logic [2*W-1:0] product;

    function automatic logic [W-1:0] append(input logic [W-1:0] acc,
                                            input logic [3:0] d,
                                            input logic dec);
        if (dec) begin
            return (acc << 3) + (acc << 1) + W'(d);
        end
        return (acc << 4) | W'(d);
    endfunction

    assign digit     = bus.key_code[3:0];
    assign key_op    = key_to_op(bus.key_code);
    assign is_digit  = bus.key_valid && !bus.key_code[4] && (!bus.dec_mode || digit < 4'd10);
    assign is_op     = bus.key_valid && (key_op != OP_NONE);
    assign is_exe    = bus.key_valid && (bus.key_code == K_EXE);
    assign is_ce     = bus.key_valid && (bus.key_code == K_CE);
    assign is_clr    = bus.key_valid && (bus.key_code == K_CLR);
    assign room      = cnt_reg < CW'(MAX_DIGITS);
    assign sum       = {1'b0, a_reg} + {1'b0, b_reg};
    assign diff      = a_reg - b_reg;
    assign start_mul = is_exe && (state_reg == S_B) && (op_reg == OP_MUL);
    // A CLR landing on the final multiply cycle loses to completion.
    assign abort_mul = is_clr && !mul_done;

    calc_seq_mult #(.W(W)) u_mult (
        .clk     (clk),
        .rst     (rst),
        .start   (start_mul),
        .abort   (abort_mul),
        .a       (a_reg),
        .b       (b_reg),
        .done    (mul_done),
        .product (product)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_reg           <= '0;
            b_reg           <= '0;
            cnt_reg         <= '0;
            op_reg          <= OP_NONE;
            state_reg       <= S_A;
            ovf_reg         <= 1'b0;
            busy_reg        <= 1'b0;
            restriction_reg <= 1'b0;
        end else begin
            restriction_reg <= bus.dec_mode;
            if (state_reg == S_MUL && mul_done) begin
                a_reg     <= product[W-1:0];
                ovf_reg   <= |product[2*W-1:W];
                busy_reg  <= 1'b0;
                state_reg <= S_RES;
            end else if (is_clr || (is_ce && state_reg == S_RES)) begin
                a_reg     <= '0;
                b_reg     <= '0;
                cnt_reg   <= '0;
                op_reg    <= OP_NONE;
                state_reg <= S_A;
                ovf_reg   <= 1'b0;
                busy_reg  <= 1'b0;
            end else begin
                case (state_reg)
                    S_A: begin
                        if (is_digit) begin
                            if (room) begin
                                a_reg   <= append(a_reg, digit, bus.dec_mode);
                                cnt_reg <= cnt_reg + CW'(1);
                            end
                        end else if (is_op) begin
                            op_reg    <= key_op;
                            state_reg <= S_OP;
                        end else if (is_ce) begin
                            a_reg   <= '0;
                            cnt_reg <= '0;
                        end
                    end
                    S_OP: begin
                        if (is_digit) begin
                            b_reg     <= W'(digit);
                            cnt_reg   <= CW'(1);
                            state_reg <= S_B;
                        end else if (is_op) begin
                            op_reg <= key_op;
                        end else if (is_ce) begin
                            op_reg    <= OP_NONE;
                            state_reg <= S_A;
                        end
                    end
                    S_B: begin
                        if (is_digit) begin
                            if (room) begin
                                b_reg   <= append(b_reg, digit, bus.dec_mode);
                                cnt_reg <= cnt_reg + CW'(1);
                            end
                        end else if (is_ce) begin
                            b_reg   <= '0;
                            cnt_reg <= '0;
                        end else if (is_exe) begin
                            state_reg <= S_RES;
                            case (op_reg)
                                OP_ADD: begin
                                    a_reg   <= sum[W-1:0];
                                    ovf_reg <= sum[W];
                                end
                                OP_SUB: begin
                                    a_reg   <= diff;
                                    ovf_reg <= a_reg < b_reg;
                                end
                                OP_AND: begin
                                    a_reg   <= a_reg & b_reg;
                                    ovf_reg <= 1'b0;
                                end
                                OP_OR: begin
                                    a_reg   <= a_reg | b_reg;
                                    ovf_reg <= 1'b0;
                                end
                                OP_MUL: begin
                                    state_reg <= S_MUL;
                                    busy_reg  <= 1'b1;
                                end
                                default: ;
                            endcase
                        end
                    end
                    S_RES: begin
                        if (is_digit) begin
                            a_reg     <= W'(digit);
                            cnt_reg   <= CW'(1);
                            ovf_reg   <= 1'b0;
                            state_reg <= S_A;
                        end else if (is_op) begin
                            op_reg    <= key_op;
                            state_reg <= S_OP;
                        end
                    end
                    S_MUL: ;
                    default: state_reg <= S_A;
                endcase
            end
        end
    end

    assign bus.display_val = (state_reg == S_B || state_reg == S_MUL) ? b_reg : a_reg;
    assign bus.op_sel      = op_reg;
    assign bus.ovf         = ovf_reg;
    assign bus.busy        = busy_reg;
    assign bus.restriction = restriction_reg;
endmodule

// File: tb/tb_calc_key_engine.sv
// Scoreboard bench: a calculator model queues expected outputs, a monitor compares them.
module tb_calc_key_engine;
    localparam int W = 16;
    localparam int KC_ADD = 16, KC_MUL = 17, KC_AND = 18, KC_EXE = 19;
    localparam int KC_SUB = 20, KC_OR = 21, KC_CE = 22, KC_CLR = 23;
    localparam int ST_A = 0, ST_OP = 1, ST_B = 2, ST_MUL = 3, ST_RES = 4;

    typedef struct {
        logic [15:0] disp;
        logic [2:0]  op;
        logic        ovf;
        logic        busy;
        logic        restr;
        logic        is_done;
    } exp_t;

    logic clk;
    logic rst_n;
    logic pending;
    exp_t exp_q[$];
    int   checks;
    int   errors;
    int   busy_cnt;
    logic busy_prev;
    int   mul_plan;
    int   seq[$];

    int unsigned     m_a, m_b, m_cnt;
    int              m_op, m_st;
    bit              m_ovf, m_restr;
    longint unsigned m_prod;

    calc_key_engine_if #(.W(W)) bus ();

    calc_key_engine #(.W(W), .MAX_DIGITS(4)) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int op_of(input int code);
        case (code)
            KC_ADD:  return 1;
            KC_SUB:  return 2;
            KC_MUL:  return 3;
            KC_AND:  return 4;
            KC_OR:   return 5;
            default: return 0;
        endcase
    endfunction

    function automatic int unsigned enter(input int unsigned acc, input int d, input bit dm);
        return dm ? (acc * 10 + d) % 65536 : (acc * 16 + d) % 65536;
    endfunction

    task automatic push_exp(input bit is_done);
        exp_t e;
        e.disp    = 16'((m_st == ST_B || m_st == ST_MUL) ? m_b : m_a);
        e.op      = 3'(m_op);
        e.ovf     = m_ovf;
        e.busy    = (m_st == ST_MUL);
        e.restr   = m_restr;
        e.is_done = is_done;
        exp_q.push_back(e);
    endtask

    task automatic model_clear();
        m_a = 0; m_b = 0; m_cnt = 0; m_op = 0; m_st = ST_A; m_ovf = 0;
    endtask

    task automatic model_key(input int code, input bit dm);
        bit dig;
        int d;
        m_restr = dm;
        dig = (code < 16) && (!dm || code < 10);
        d = code % 16;
        if (m_st == ST_MUL) begin
            if (code == KC_CLR) model_clear();
        end else if (code == KC_CLR || (code == KC_CE && m_st == ST_RES)) begin
            model_clear();
        end else begin
            case (m_st)
                ST_A: begin
                    if (dig) begin
                        if (m_cnt < 4) begin m_a = enter(m_a, d, dm); m_cnt++; end
                    end else if (op_of(code) != 0) begin
                        m_op = op_of(code); m_st = ST_OP;
                    end else if (code == KC_CE) begin
                        m_a = 0; m_cnt = 0;
                    end
                end
                ST_OP: begin
                    if (dig) begin
                        m_b = d; m_cnt = 1; m_st = ST_B;
                    end else if (op_of(code) != 0) begin
                        m_op = op_of(code);
                    end else if (code == KC_CE) begin
                        m_op = 0; m_st = ST_A;
                    end
                end
                ST_B: begin
                    if (dig) begin
                        if (m_cnt < 4) begin m_b = enter(m_b, d, dm); m_cnt++; end
                    end else if (code == KC_CE) begin
                        m_b = 0; m_cnt = 0;
                    end else if (code == KC_EXE) begin
                        m_st = ST_RES;
                        case (m_op)
                            1: begin m_ovf = (m_a + m_b) > 65535; m_a = (m_a + m_b) % 65536; end
                            2: begin m_ovf = m_a < m_b; m_a = (m_a + 65536 - m_b) % 65536; end
                            3: begin m_prod = longint'(m_a) * longint'(m_b); m_st = ST_MUL; end
                            4: begin m_a = m_a & m_b; m_ovf = 0; end
                            5: begin m_a = m_a | m_b; m_ovf = 0; end
                            default: ;
                        endcase
                    end
                end
                ST_RES: begin
                    if (dig) begin
                        m_a = d; m_cnt = 1; m_ovf = 0; m_st = ST_A;
                    end else if (op_of(code) != 0) begin
                        m_op = op_of(code); m_st = ST_OP;
                    end
                end
                default: ;
            endcase
        end
        push_exp(1'b0);
    endtask

    task automatic model_complete();
        m_a   = int'(m_prod % 65536);
        m_ovf = m_prod > 65535;
        m_st  = ST_RES;
        push_exp(1'b1);
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_display"}, 32'(bus.display_val), 32'h0);
        chk({tag, "_op_sel"}, 32'(bus.op_sel), 32'h0);
        chk({tag, "_ovf"}, 32'(bus.ovf), 32'h0);
        chk({tag, "_busy"}, 32'(bus.busy), 32'h0);
        chk({tag, "_restriction"}, 32'(bus.restriction), 32'h0);
    endtask

    // Called at a falling edge; reset is asserted and released away from rising edges.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1 check_zero_outputs("async_reset");
        model_clear();
        m_restr = 0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic run_mul();
        int  abort_c, rst_c, code;
        bit  rnd;
        abort_c = 0;
        rst_c   = 0;
        rnd     = (mul_plan < 0);
        if (rnd) begin
            if ($urandom_range(0, 3) == 0) abort_c = $urandom_range(1, W - 1);
        end else if (mul_plan >= 100) begin
            rst_c = mul_plan - 100;
        end else begin
            abort_c = mul_plan;
        end
        for (int c = 1; c <= W; c++) begin
            bus.key_valid = 1'b0;
            if (rst_c == c) begin
                do_reset();
                return;
            end
            if (c == W) begin
                if (rnd && $urandom_range(0, 1) == 1) begin
                    bus.key_valid = 1'b1;
                    bus.key_code  = 5'($urandom_range(0, 31));
                end
                model_complete();
            end else if (c == abort_c) begin
                bus.key_valid = 1'b1;
                bus.key_code  = 5'(KC_CLR);
                model_key(KC_CLR, bus.dec_mode);
                @(negedge clk);
                bus.key_valid = 1'b0;
                return;
            end else if (rnd && $urandom_range(0, 2) == 0) begin
                code = $urandom_range(0, 22);
                bus.key_valid = 1'b1;
                bus.key_code  = 5'(code);
                model_key(code, bus.dec_mode);
            end
            @(negedge clk);
        end
        bus.key_valid = 1'b0;
    endtask

    task automatic press(input int code, input bit dm);
        bus.key_valid = 1'b1;
        bus.key_code  = 5'(code);
        bus.dec_mode  = dm;
        model_key(code, dm);
        @(negedge clk);
        bus.key_valid = 1'b0;
        if (m_st == ST_MUL) run_mul();
    endtask

    task automatic play(input bit dm);
        foreach (seq[i]) press(seq[i], dm);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) pending <= 1'b0;
        else        pending <= bus.key_valid;
    end

    always @(negedge clk) begin : monitor
        bit   fell;
        exp_t e;
        if (!rst_n) begin
            busy_prev = 1'b0;
            busy_cnt  = 0;
        end else begin
            if (bus.busy) busy_cnt++;
            fell = busy_prev && !bus.busy;
            if (pending || fell) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event actual=event required=none at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    $display("t=%0t disp=%h op=%0d ovf=%0b busy=%0b restr=%0b (want %h %0d %0b %0b %0b)",
                             $time, bus.display_val, bus.op_sel, bus.ovf, bus.busy, bus.restriction,
                             e.disp, e.op, e.ovf, e.busy, e.restr);
                    chk("display_val", 32'(bus.display_val), 32'(e.disp));
                    chk("op_sel", 32'(bus.op_sel), 32'(e.op));
                    chk("ovf", 32'(bus.ovf), 32'(e.ovf));
                    chk("busy", 32'(bus.busy), 32'(e.busy));
                    chk("restriction", 32'(bus.restriction), 32'(e.restr));
                    if (e.is_done) chk("busy_cycles", 32'(busy_cnt), 32'(W));
                end
            end
            if (fell) busy_cnt = 0;
            busy_prev = bus.busy;
        end
    end

    initial begin
        bit dm;
        int code;
        checks = 0; errors = 0; busy_cnt = 0; busy_prev = 1'b0;
        mul_plan = 0;
        rst_n = 1'b0;
        bus.key_valid = 1'b0; bus.key_code = 5'h0; bus.dec_mode = 1'b0;
        model_clear();
        m_restr = 0;
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        #2 rst_n = 1'b1;
        @(negedge clk);

        seq = '{KC_CLR, 1, 2, KC_ADD, 3, 4, KC_EXE};                play(1'b0);
        seq = '{KC_CLR, 9, 9, KC_MUL, 1, 2, KC_EXE};  mul_plan = 0;  play(1'b1);
        seq = '{KC_CLR, 3, KC_SUB, 5, KC_EXE, 7};                   play(1'b0);
        seq = '{KC_CLR, 1, 2, 3, 4, 5};                             play(1'b0);
        press(10, 1'b1);
        seq = '{KC_CLR, 10, 7, 11, 3};                              play(1'b1);
        seq = '{KC_CLR, 2, KC_MUL, 3, KC_EXE};        mul_plan = 5;   play(1'b0);
        seq = '{KC_CLR, 2, KC_MUL, 3, KC_EXE};        mul_plan = 108; play(1'b0);
        seq = '{KC_CLR, 5, KC_ADD, 6, KC_EXE, KC_OR, 8, KC_EXE};    play(1'b0);
        seq = '{KC_CLR, 5, KC_ADD, 6, KC_EXE, KC_OR, 8, KC_CE, KC_EXE}; play(1'b0);
        seq = '{KC_CLR, 15, 15, 15, 15, KC_MUL, 15, 15, 15, 15, KC_EXE}; mul_plan = 0; play(1'b0);

        mul_plan = -1;
        dm = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) dm = ~dm;
            code = ($urandom_range(0, 15) == 0) ? $urandom_range(24, 31) : $urandom_range(0, 23);
            if (code == KC_CLR && $urandom_range(0, 3) != 0) code = $urandom_range(0, 9);
            press(code, dm);
        end

        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
